gpia_input: RTL and testbench

GPIA_INPUT -- requirements
Module: gpia_input

---
 rtl/gpia_pkg.sv | 34 +++
 rtl/gpia_input_if.sv | 26 ++
 rtl/gpia_inbit.sv | 51 +++++
 rtl/gpia_input.sv | 106 ++++++++++
 tb/tb_gpia_input.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpia_pkg.sv
// rtl/gpia_pkg.sv - shared constants and helpers for the GPIA input block
//   ADR_*       : register select values seen on adr_i
//   gpia_bit_e  : per-pin edge sensitivity mode, encoded as {FALL, RISE}
//   gpia_edge() : edge qualifier for one pin given its mode and two samples
package gpia_pkg;

  localparam logic [2:0] ADR_LEVEL = 3'd0;
  localparam logic [2:0] ADR_FLAGS = 3'd1;
  localparam logic [2:0] ADR_IE    = 3'd2;
  localparam logic [2:0] ADR_RISE  = 3'd3;
  localparam logic [2:0] ADR_FALL  = 3'd4;

  typedef enum logic [1:0] {
    GPIA_BIT_OFF  = 2'b00,
    GPIA_BIT_RISE = 2'b01,
    GPIA_BIT_FALL = 2'b10,
    GPIA_BIT_BOTH = 2'b11
  } gpia_bit_e;

  // cur is the newest synchronized sample, prev the one before it.
  function automatic logic gpia_edge(gpia_bit_e mode, logic cur, logic prev);
    logic rose;
    logic fell;
    rose = cur & ~prev;
    fell = ~cur & prev;
    case (mode)
      GPIA_BIT_RISE: return rose;
      GPIA_BIT_FALL: return fell;
      GPIA_BIT_BOTH: return rose | fell;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gpia_input_if.sv
// rtl/gpia_input_if.sv - register bus between a bus master and gpia_input
//   stb_i : transaction strobe        we_i  : 1 = write, 0 = read
//   adr_i : register select (3 bits)  dat_i : write data (W bits)
//   dat_o : registered read data      ack_o : one-cycle acknowledge
interface gpia_input_if #(
  parameter int W = 8
);

  logic         stb_i;
  logic         we_i;
  logic [2:0]   adr_i;
  logic [W-1:0] dat_i;
  logic [W-1:0] dat_o;
  logic         ack_o;

  modport master (
    output stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o
  );

endinterface

// File: rtl/gpia_inbit.sv
// rtl/gpia_inbit.sv - one input pin: synchronizer, history, edge detect, sticky flag
//   clk_i, res_i      : clock, asynchronous active-low reset
//   pin_i             : raw pin, asynchronous to clk_i
//   arm_i             : global edge-detect enable from the arm counter
//   rise_i, fall_i    : edge sensitivity for this pin
//   clr_i             : write-1-to-clear request for the flag
//   level_o           : synchronized pin level (s2)
//   flag_o            : sticky edge flag
module gpia_inbit
  import gpia_pkg::*;
(
  input  logic clk_i,
  input  logic res_i,
  input  logic pin_i,
  input  logic arm_i,
  input  logic rise_i,
  input  logic fall_i,
  input  logic clr_i,
  output logic level_o,
  output logic flag_o
);

  logic      r_s1;
  logic      r_s2;
  logic      r_h;
  logic      r_flag;
  gpia_bit_e w_mode;
  logic      w_event;

  assign w_mode  = gpia_bit_e'({fall_i, rise_i});
  assign w_event = arm_i & gpia_edge(w_mode, r_s2, r_h);

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_h    <= 1'b0;
      r_flag <= 1'b0;
    end else begin
      r_s1   <= pin_i;
      r_s2   <= r_s1;
      r_h    <= r_s2;
      // A new event outranks a clear landing on the same edge.
      r_flag <= w_event | (r_flag & ~clr_i);
    end
  end

  assign level_o = r_s2;
  assign flag_o  = r_flag;

endmodule

// File: rtl/gpia_input.sv
// rtl/gpia_input.sv - W-pin edge-detecting input port with register bus and interrupt
//   clk_i  : system clock          res_i : asynchronous active-low reset
//   pins_i : external pins (async) irq_o : |(FLAGS & IE)
//   bus    : register bus slave (stb_i/we_i/adr_i/dat_i in, dat_o/ack_o out)
//   Registers: 0 LEVEL (ro), 1 FLAGS (w1c), 2 IE, 3 RISE, 4 FALL, 5-7 read 0
module gpia_input
  import gpia_pkg::*;
#(
  parameter int W = 8
) (
  input  logic          clk_i,
  input  logic          res_i,
  input  logic [W-1:0]  pins_i,
  gpia_input_if.slave   bus,
  output logic          irq_o
);

  logic [W-1:0] r_ie;
  logic [W-1:0] r_rise;
  logic [W-1:0] r_fall;
  logic [W-1:0] r_dat;
  logic         r_ack;
  logic [1:0]   r_arm_cnt;
  logic         r_arm;

  logic [W-1:0] w_level;
  logic [W-1:0] w_flags;
  logic [W-1:0] w_clr;
  logic [W-1:0] w_rdata;
  logic         w_wr;

  assign w_wr  = bus.stb_i & bus.we_i;
  assign w_clr = (w_wr && bus.adr_i == ADR_FLAGS) ? bus.dat_i : '0;

  for (genvar b = 0; b < W; b++) begin : g_bit
    gpia_inbit u_bit (
      .clk_i   (clk_i),
      .res_i   (res_i),
      .pin_i   (pins_i[b]),
      .arm_i   (r_arm),
      .rise_i  (r_rise[b]),
      .fall_i  (r_fall[b]),
      .clr_i   (w_clr[b]),
      .level_o (w_level[b]),
      .flag_o  (w_flags[b])
    );
  end

  always_comb begin
    w_rdata = '0;
    case (bus.adr_i)
      ADR_LEVEL: w_rdata = w_level;
      ADR_FLAGS: w_rdata = w_flags;
      ADR_IE:    w_rdata = r_ie;
      ADR_RISE:  w_rdata = r_rise;
      ADR_FALL:  w_rdata = r_fall;
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      r_ie   <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_dat  <= '0;
      r_ack  <= 1'b0;
    end else begin
      if (w_wr) begin
        case (bus.adr_i)
          ADR_IE:   r_ie   <= bus.dat_i;
          ADR_RISE: r_rise <= bus.dat_i;
          ADR_FALL: r_fall <= bus.dat_i;
          default:  ;
        endcase
      end
      if (bus.stb_i) begin
        r_dat <= bus.we_i ? '0 : w_rdata;
      end
      // Held strobe toggles ack, giving one ack every other cycle.
      r_ack <= bus.stb_i & ~r_ack;
    end
  end

  // Pins held high through reset look like rising edges while the
  // synchronizer refills; arm stays low for the first three edges so
  // those edges never reach FLAGS.
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      r_arm_cnt <= 2'd0;
      r_arm     <= 1'b0;
    end else begin
      if (r_arm_cnt != 2'd3) begin
        r_arm_cnt <= r_arm_cnt + 2'd1;
      end
      if (r_arm_cnt == 2'd2) begin
        r_arm <= 1'b1;
      end
    end
  end

  assign bus.dat_o = r_dat;
  assign bus.ack_o = r_ack;
  assign irq_o     = |(w_flags & r_ie);

endmodule

// File: tb/tb_gpia_input.sv
// tb/tb_gpia_input.sv - scoreboard bench for gpia_input with a sample-history reference model
module tb_gpia_input;

  logic       clk;
  logic       rst_n;
  logic [7:0] pins;
  logic       irq;

  gpia_input_if #(.W(8)) bus ();

  gpia_input #(.W(8)) dut (
    .clk_i  (clk),
    .res_i  (rst_n),
    .pins_i (pins),
    .bus    (bus),
    .irq_o  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every pin sample taken since reset release is kept.
  // At edge k, LEVEL shows sample k-2 and an edge between samples k-3 and
  // k-2 flags, but only from the fourth edge after release onward.
  logic [7:0] hist[$];
  logic [7:0] exp_q[$];
  int         k;
  logic [7:0] m_flags, m_ie, m_rise, m_fall;
  bit         m_ack;

  function automatic logic [7:0] samp(int j);
    if (j < 1 || j > hist.size()) return 8'h00;
    return hist[j-1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] cur, prev, ev, rd, clr;
    if (!rst_n) begin
      hist.delete();
      exp_q.delete();
      k = 0;
      m_flags = 0; m_ie = 0; m_rise = 0; m_fall = 0;
      m_ack = 0;
    end else begin
      k++;
      cur  = samp(k - 2);
      prev = samp(k - 3);
      ev   = (k >= 4) ? ((m_rise & cur & ~prev) | (m_fall & ~cur & prev)) : 8'h00;
      case (bus.adr_i)
        3'd0:    rd = cur;
        3'd1:    rd = m_flags;
        3'd2:    rd = m_ie;
        3'd3:    rd = m_rise;
        3'd4:    rd = m_fall;
        default: rd = 8'h00;
      endcase
      if (bus.stb_i && !m_ack) exp_q.push_back(bus.we_i ? 8'h00 : rd);
      m_ack = bus.stb_i && !m_ack;
      clr = 8'h00;
      if (bus.stb_i && bus.we_i) begin
        case (bus.adr_i)
          3'd1: clr    = bus.dat_i;
          3'd2: m_ie   = bus.dat_i;
          3'd3: m_rise = bus.dat_i;
          3'd4: m_fall = bus.dat_i;
          default: ;
        endcase
      end
      m_flags = ev | (m_flags & ~clr);
      hist.push_back(pins);
    end
  end

  // Monitor: pops one expectation per acknowledge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      check("reset_dat_o", bus.dat_o, 0);
      check("reset_ack_o", bus.ack_o, 0);
      check("reset_irq_o", irq, 0);
    end else begin
      check("irq_o", irq, |(m_flags & m_ie));
      if (bus.ack_o) begin
        if (exp_q.size() == 0) begin
          check("ack_without_request", bus.ack_o, 0);
        end else begin
          e = exp_q.pop_front();
          check("read_data", bus.dat_o, e);
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [2:0] a, logic [7:0] d);
    bus.stb_i = 1; bus.we_i = 1; bus.adr_i = a; bus.dat_i = d;
    @(posedge clk); #1;
    bus.stb_i = 0; bus.we_i = 0;
    @(posedge clk); #1;
  endtask

  task automatic rd(logic [2:0] a, output logic [7:0] d);
    bus.stb_i = 1; bus.we_i = 0; bus.adr_i = a;
    @(posedge clk); #1;
    bus.stb_i = 0;
    d = bus.dat_o;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] d;
    rst_n = 0; pins = 8'hFF;
    bus.stb_i = 0; bus.we_i = 0; bus.adr_i = 0; bus.dat_i = 0;
    idle(3);
    rst_n = 1;

    // Pins high through reset must not flag.
    wr(3'd3, 8'hFF);
    rd(3'd1, d); check("req030_flags", d, 8'h00);
    rd(3'd0, d); check("req030_level", d, 8'hFF);

    // Rising edge on bit 0: LEVEL after E1, FLAGS/irq after E2.
    wr(3'd4, 8'h00); wr(3'd3, 8'h01); wr(3'd2, 8'h01);
    pins = 8'h00; idle(4);
    wr(3'd1, 8'hFF);
    pins[0] = 1'b1;
    idle(1);
    idle(1); check("req031_irq_e1", irq, 0);
    idle(1); check("req031_irq_e2", irq, 1);
    rd(3'd0, d); check("req031_level", d, 8'h01);
    rd(3'd1, d); check("req031_flags", d, 8'h01);

    // Falling edge on bit 7, then clear it.
    wr(3'd1, 8'hFF); wr(3'd3, 8'h00); wr(3'd4, 8'h80); wr(3'd2, 8'h80);
    pins[7] = 1'b1; idle(4);
    pins[7] = 1'b0; idle(4);
    check("req032_irq_set", irq, 1);
    bus.stb_i = 1; bus.we_i = 1; bus.adr_i = 3'd1; bus.dat_i = 8'h80;
    @(posedge clk); #1;
    bus.stb_i = 0; bus.we_i = 0;
    check("req032_irq_clr", irq, 0);
    idle(1);
    rd(3'd1, d); check("req032_flags", d, 8'h00);

    // Clear and set on the same edge: set wins.
    wr(3'd4, 8'h00); wr(3'd3, 8'h01); wr(3'd2, 8'h01);
    pins[0] = 1'b0; idle(4);
    wr(3'd1, 8'hFF);
    pins[0] = 1'b1;
    idle(2);
    bus.stb_i = 1; bus.we_i = 1; bus.adr_i = 3'd1; bus.dat_i = 8'h01;
    @(posedge clk); #1;
    bus.stb_i = 0; bus.we_i = 0;
    check("req033_irq", irq, 1);
    idle(1);
    rd(3'd1, d); check("req033_flags", d, 8'h01);

    // Readback, unmapped address, and held strobe.
    wr(3'd3, 8'h5A);
    rd(3'd3, d); check("req034_rise", d, 8'h5A);
    wr(3'd6, 8'hFF);
    rd(3'd6, d); check("req034_unmapped", d, 8'h00);
    bus.stb_i = 1; bus.we_i = 0; bus.adr_i = 3'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("req022_held_ack", bus.ack_o, (i % 2 == 0) ? 1 : 0);
    end
    bus.stb_i = 0;
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) pins = 8'($urandom);
      case ($urandom_range(0, 3))
        0: rd(3'($urandom_range(0, 7)), d);
        1: wr(3'($urandom_range(0, 7)), 8'($urandom));
        2: idle($urandom_range(1, 3));
        default: rd(3'd1, d);
      endcase
    end

    // Reset during a pending flag and an open read.
    wr(3'd2, 8'hFF); wr(3'd3, 8'hFF); wr(3'd4, 8'hFF);
    pins = ~pins; idle(4);
    check("req035_irq_before", irq, 1);
    bus.stb_i = 1; bus.we_i = 0; bus.adr_i = 3'd1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("req035_irq", irq, 0);
    check("req035_ack", bus.ack_o, 0);
    check("req035_dat", bus.dat_o, 0);
    bus.stb_i = 0;
    idle(2);
    rst_n = 1;
    idle(4);
    rd(3'd1, d); check("req035_flags", d, 8'h00);
    rd(3'd2, d); check("req035_ie", d, 8'h00);

    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
